// File: rtl/ps2_key_receiver_if.sv
// PS/2 keyboard pins in, decoded scan-code strobe out.
// master = keyboard/test side, slave = ps2_key_receiver.
interface ps2_key_receiver_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] ps2_out;
  logic       ps2_key_pressed;
  logic       ps2_ext;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_dat,
    input  ps2_out, ps2_key_pressed, ps2_ext, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output ps2_out, ps2_key_pressed, ps2_ext, frame_err
  );
endinterface

// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix tracking, iVGA_CLK domain.
// Define PS2_BREAK_FILTER_EN to swallow E0/F0 prefixes and break codes (make codes only).
module ps2_key_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  ps2_key_receiver_if.slave bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN);
  localparam logic [14:0]   TMO_MAX = 15'(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_s, dat_s;
  logic          filt, filt_d, fall;
  logic [FW-1:0] fcnt, fcnt_nxt;

  logic [1:0]    state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [14:0]   tmo;
  logic          tmo_hit, byte_ok, frame_bad;

  logic [7:0]    out_q;
  logic          kp_q, ext_q, err_q, ext_pending;

  // ---------------- synchronizers ----------------
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], bus.ps2_clk};
      dat_sync <= {dat_sync[0], bus.ps2_dat};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // ---------------- clock de-glitch filter ----------------
  assign fcnt_nxt = (fcnt == FLT_MAX) ? fcnt : fcnt + 1'b1;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      filt_d <= filt;
      if (clk_s == filt) begin
        fcnt <= '0;
      end else if (fcnt_nxt == FLT_MAX) begin
        filt <= clk_s;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt_nxt;
      end
    end
  end

  assign fall = filt_d & ~filt;

  // ---------------- frame FSM ----------------
  // fall clears the watchdog in the same cycle, so it always wins over a timeout.
  assign tmo_hit   = (state != IDLE) && !fall && (tmo == TMO_MAX);
  assign byte_ok   = fall && (state == STOP) && dat_s && (^{shreg, par_bit});
  assign frame_bad = tmo_hit || (fall && (state == STOP) && !(dat_s && (^{shreg, par_bit})));

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      tmo <= '0;
    end else if (state == IDLE || fall) begin
      tmo <= '0;
    end else if (tmo != '1) begin
      tmo <= tmo + 1'b1;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state   <= IDLE;
      bitcnt  <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (fall) begin
      case (state)
        IDLE: begin
          // a high bit here is a stray edge, not a start bit
          if (!dat_s) begin
            state  <= DATA;
            bitcnt <= '0;
          end
        end
        DATA: begin
          shreg  <= {dat_s, shreg[7:1]};
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == 3'd7) state <= PARITY;
        end
        PARITY: begin
          par_bit <= dat_s;
          state   <= STOP;
        end
        default: state <= IDLE;
      endcase
    end else if (tmo_hit) begin
      state <= IDLE;
    end
  end

  // ---------------- byte delivery / prefix tracking ----------------
`ifdef PS2_BREAK_FILTER_EN
  logic brk_pending;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      out_q       <= 8'h00;
      kp_q        <= 1'b0;
      ext_q       <= 1'b0;
      err_q       <= 1'b0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
    end else begin
      kp_q  <= 1'b0;
      err_q <= 1'b0;
      if (frame_bad) begin
        err_q       <= 1'b1;
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (byte_ok) begin
        // the byte after F0 is a break code: drop it and end the sequence
        if (brk_pending) begin
          brk_pending <= 1'b0;
          ext_pending <= 1'b0;
        end else if (shreg == CODE_EXT) begin
          ext_pending <= 1'b1;
        end else if (shreg == CODE_BRK) begin
          brk_pending <= 1'b1;
        end else begin
          out_q       <= shreg;
          ext_q       <= ext_pending;
          kp_q        <= 1'b1;
          ext_pending <= 1'b0;
        end
      end
    end
  end
`else
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      out_q       <= 8'h00;
      kp_q        <= 1'b0;
      ext_q       <= 1'b0;
      err_q       <= 1'b0;
      ext_pending <= 1'b0;
    end else begin
      kp_q  <= 1'b0;
      err_q <= 1'b0;
      if (frame_bad) begin
        err_q       <= 1'b1;
        ext_pending <= 1'b0;
      end else if (byte_ok) begin
        // every byte is delivered; E0 still flags the byte after it
        out_q       <= shreg;
        ext_q       <= ext_pending;
        kp_q        <= 1'b1;
        ext_pending <= (shreg == CODE_EXT);
      end
    end
  end
`endif

  assign bus.ps2_out         = out_q;
  assign bus.ps2_key_pressed = kp_q;
  assign bus.ps2_ext         = ext_q;
  assign bus.frame_err       = err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: vector table, corner sequences, random frames vs model.
module tb_ps2_key_receiver;

  localparam int HALF = 40;
`ifdef PS2_BREAK_FILTER_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_key_receiver_if bus();

  ps2_key_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(25000)) dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .bus      (bus)
  );

  int checks = 0, errors = 0;
  int cyc = 0, n_strobe = 0, n_err = 0, strobe_cyc = 0, last_fall_cyc = 0, wide = 0;
  logic prev_kp = 1'b0;
  logic [8:0] act_q[$];
  logic [8:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ps2_key_pressed) begin
      n_strobe++;
      strobe_cyc = cyc;
      act_q.push_back({bus.ps2_ext, bus.ps2_out});
      if (prev_kp) wide++;
    end
    if (bus.frame_err) n_err++;
    prev_kp = bus.ps2_key_pressed;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit pflip, input bit sbad);
    return {~sbad, (~^b) ^ pflip, b, 1'b0};
  endfunction

  // bit i is set up mid-high, then clocked by a falling edge; optional short glitches
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_dat = bits[i];
      tick(HALF/2);
      bus.ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (glitch && i == 6) begin
        tick(10); bus.ps2_clk = 1'b1; tick(2); bus.ps2_clk = 1'b0; tick(HALF-12);
      end else begin
        tick(HALF);
      end
      bus.ps2_clk = 1'b1;
      if (glitch && i == 4) begin
        tick(5); bus.ps2_clk = 1'b0; tick(3); bus.ps2_clk = 1'b1; tick(HALF/2-8);
      end else begin
        tick(HALF/2);
      end
    end
    bus.ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pflip, input bit sbad, input bit glitch);
    send_bits(frame_bits(b, pflip, sbad), 11, glitch);
    tick(20);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         pflip;
    bit         sbad;
    int         strobes;
    logic [7:0] out;
    bit         ext;
    int         errs;
  } vec_t;

  vec_t tbl[10];

  // reference model state: decoder rules applied per received frame
  bit m_ext, m_brk;
  int m_err;

  task automatic model(input logic [7:0] b, input bit bad);
    if (bad) begin
      m_err++; m_ext = 0; m_brk = 0;
    end else if (BRK) begin
      if (m_brk) begin m_brk = 0; m_ext = 0; end
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin exp_q.push_back({m_ext, b}); m_ext = 0; end
    end else begin
      exp_q.push_back({m_ext, b});
      m_ext = (b == 8'hE0);
    end
  endtask

  initial begin
    int s0, e0;
    logic [7:0] pv_out;
    bit pv_ext;

    tbl[0] = '{8'h75, 0, 0, 1, 8'h75, 0, 0};
    tbl[1] = '{8'h6B, 1, 0, 0, 8'h75, 0, 1};
    tbl[2] = '{8'hE0, 0, 0, BRK ? 0 : 1, BRK ? 8'h75 : 8'hE0, 0, 0};
    tbl[3] = '{8'h6B, 0, 0, 1, 8'h6B, 1, 0};
    tbl[4] = '{8'hF0, 0, 0, BRK ? 0 : 1, BRK ? 8'h6B : 8'hF0, BRK, 0};
    tbl[5] = '{8'h75, 0, 0, BRK ? 0 : 1, BRK ? 8'h6B : 8'h75, BRK, 0};
    pv_out = BRK ? 8'h6B : 8'h75;
    pv_ext = BRK;
    tbl[6] = '{8'h1C, 0, 1, 0, pv_out, pv_ext, 1};
    tbl[7] = '{8'hE0, 0, 0, BRK ? 0 : 1, BRK ? 8'h6B : 8'hE0, BRK, 0};
    pv_out = BRK ? 8'h6B : 8'hE0;
    tbl[8] = '{8'h74, 1, 0, 0, pv_out, pv_ext, 1};
    tbl[9] = '{8'h74, 0, 0, 1, 8'h74, 0, 0};

    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    tick(4);
    check("reset_out",  bus.ps2_out, 8'h00);
    check("reset_kp",   bus.ps2_key_pressed, 0);
    check("reset_ext",  bus.ps2_ext, 0);
    check("reset_ferr", bus.frame_err, 0);
    rst_n = 1'b1;
    tick(20);

    // vector table
    for (int i = 0; i < 10; i++) begin
      s0 = n_strobe; e0 = n_err;
      send_frame(tbl[i].data, tbl[i].pflip, tbl[i].sbad, 1'b0);
      check($sformatf("vec%0d_strobes", i), n_strobe - s0, tbl[i].strobes);
      check($sformatf("vec%0d_out", i),     bus.ps2_out, tbl[i].out);
      check($sformatf("vec%0d_ext", i),     bus.ps2_ext, tbl[i].ext);
      check($sformatf("vec%0d_errs", i),    n_err - e0, tbl[i].errs);
    end

    // latency from raw 11th falling edge to strobe, and strobe width
    s0 = n_strobe;
    send_frame(8'h75, 0, 0, 0);
    check("lat_strobes", n_strobe - s0, 1);
    check("lat_cycles", strobe_cyc - last_fall_cyc, 11);
    check("lat_out", bus.ps2_out, 8'h75);

    // abandoned frame: start + 5 data bits, then silence
    s0 = n_strobe; e0 = n_err;
    send_bits(frame_bits(8'h72, 0, 0), 6, 0);
    tick(25100);
    check("tmo_errs", n_err - e0, 1);
    check("tmo_strobes", n_strobe - s0, 0);
    check("tmo_out_kept", bus.ps2_out, 8'h75);
    send_frame(8'h72, 0, 0, 0);
    check("post_tmo_strobes", n_strobe - s0, 1);
    check("post_tmo_out", bus.ps2_out, 8'h72);
    check("post_tmo_ext", bus.ps2_ext, 0);
    check("post_tmo_errs", n_err - e0, 1);

    // short clock glitches inside a frame
    s0 = n_strobe; e0 = n_err;
    send_frame(8'h74, 0, 0, 1);
    check("glitch_strobes", n_strobe - s0, 1);
    check("glitch_out", bus.ps2_out, 8'h74);
    check("glitch_errs", n_err - e0, 0);

    // reset mid-frame
    send_bits(frame_bits(8'h1C, 0, 0), 4, 0);
    rst_n = 1'b0;
    tick(3);
    check("midrst_out",  bus.ps2_out, 8'h00);
    check("midrst_kp",   bus.ps2_key_pressed, 0);
    check("midrst_ext",  bus.ps2_ext, 0);
    check("midrst_ferr", bus.frame_err, 0);
    rst_n = 1'b1;
    tick(50);
    s0 = n_strobe; e0 = n_err;
    send_frame(8'h74, 0, 0, 0);
    check("postrst_strobes", n_strobe - s0, 1);
    check("postrst_out", bus.ps2_out, 8'h74);
    check("postrst_ext", bus.ps2_ext, 0);
    check("postrst_errs", n_err - e0, 0);

    // randomized frames against the model
    act_q.delete();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_err = 0;
    e0 = n_err;
    for (int i = 0; i < 25; i++) begin
      logic [7:0] b;
      bit pf, sb;
      int r;
      r  = $urandom_range(0, 9);
      b  = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      pf = ($urandom_range(0, 7) == 0);
      sb = ($urandom_range(0, 11) == 0);
      model(b, pf | sb);
      send_frame(b, pf, sb, 0);
    end
    check("rnd_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("rnd_strobe%0d", i), act_q[i], exp_q[i]);
    check("rnd_errs", n_err - e0, m_err);
    check("strobe_width", wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_receiver.md
# ps2_key_receiver

- Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_dat` pins and decodes scan-code bytes.
- Drives the `ps2_out`/`ps2_key_pressed` pair consumed by the VGA controller's square-movement logic.
- All logic runs in the `iVGA_CLK` domain. The PS/2 lines are asynchronous and are synchronized and de-glitched internally.
- Prefix bytes (E0 extended, F0 break) are tracked so the downstream consumer sees clean make codes plus an extended flag.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical synchronized samples needed before the filtered PS/2 clock changes level (range 2–255).
- `TIMEOUT_CYCLES`, default 25000: `iVGA_CLK` cycles without a filtered falling edge before an in-progress frame is abandoned (1 ms at 25 MHz).
- `iVGA_CLK`  in  1: system/pixel clock; all state is updated on its rising edge.
- `iRST_n`  in  1: reset, asynchronous, active-low.
- `ps2_clk`  in  1: raw PS/2 clock from the keyboard, asynchronous.
- `ps2_dat`  in  1: raw PS/2 data from the keyboard, asynchronous.
- `ps2_out`  out  8: last delivered scan code; holds its value between strobes.
- `ps2_key_pressed`  out  1: one-cycle strobe; `ps2_out` and `ps2_ext` are valid in the same cycle.
- `ps2_ext`  out  1: 1 when the delivered code was preceded by E0.
- `frame_err`  out  1: one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Synchronizer:** two-flop synchronizer on each of `ps2_clk` and `ps2_dat`.
- **Clock filter:** the filtered clock starts at 1. A saturating counter of width ceil(log2(FILTER_LEN+1)) counts consecutive synchronized samples that differ from the filtered level. The filtered level flips when the counter reaches `FILTER_LEN`. Any sample equal to the current level clears the counter.
- **Falling edge:** `fall` is a one-cycle pulse when the filtered clock goes 1→0. The synchronized data bit is sampled in that same cycle.
- **FSM states** (each transition happens on `fall` unless noted):
  - IDLE: if data = 0 (start bit), go to DATA with bit count 0. If data = 1, stay in IDLE silently (treated as a glitch).
  - DATA: shift the bit into `shreg` LSB-first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: the frame is valid if the stop bit = 1 and XOR(`shreg`, parity) = 1 (odd parity). Return to IDLE in either case.
  - Any state other than IDLE: if the timeout counter reaches `TIMEOUT_CYCLES`, go to IDLE and pulse `frame_err`.
- **Timeout counter:** 15 bits, clears on every `fall` and in IDLE, saturates.
- **Valid byte handling:** prefix handling follows the Configuration section. When a byte is delivered: `ps2_out`←byte, `ps2_ext`←`ext_pending`, then clear `ext_pending`.
- **Invalid frame:** pulse `frame_err`, clear `ext_pending` and `brk_pending`, no strobe, `ps2_out` unchanged.
- **Reset:** `ps2_out`=8'h00, `ps2_key_pressed`=0, `ps2_ext`=0, `frame_err`=0, FSM=IDLE, filtered clock=1, all counters and pending flags = 0.
- **Reset mid-frame:** the partial frame is discarded. The next frame is received only from its own start bit.
- **Simultaneous events:** timeout and `fall` cannot coincide because `fall` clears the counter first. A frame completing with an error never also strobes.

## Timing
- Raw `ps2_clk` falling edge to `fall` asserted: `FILTER_LEN`+2 cycles (2 synchronizer + `FILTER_LEN` filter), with a stable input assumed.
- `fall` of the stop bit to `ps2_key_pressed`/`frame_err` high: 1 cycle, registered. Strobe width is exactly 1 cycle.
- Total latency from the raw 11th falling edge to the strobe: `FILTER_LEN`+3 cycles.
- Back-to-back frames are supported with no dead time beyond the PS/2 idle bit.
- Host-to-device transmission is not supported. `ps2_clk` and `ps2_dat` are input-only.

## Configuration
- Macro: `PS2_BREAK_FILTER_EN`.
- **Defined:**
  - E0 sets `ext_pending` and produces no strobe.
  - F0 sets `brk_pending` and produces no strobe.
  - A byte received while `brk_pending`=1 is consumed silently, then both pending flags are cleared.
  - Only make codes strobe.
- **Undefined:**
  - Every valid byte strobes, including E0 and F0.
  - `ext_pending` is still set by E0 and applied to the following byte.
  - `brk_pending` logic is absent.

## Test plan
- Frame 0x75 with correct parity (0), `FILTER_LEN`=8 → `ps2_out`=8'h75, `ps2_ext`=0, one-cycle strobe 11 cycles after the raw 11th edge, `frame_err`=0.
- Frame 0x6B with parity forced to 1 → `frame_err` pulses once, no strobe, `ps2_out` keeps its previous value.
- Sequence E0, 6B → strobe with `ps2_out`=8'h6B, `ps2_ext`=1. With `PS2_BREAK_FILTER_EN` defined, no strobe for E0.
- Sequence F0, 75 with macro defined → zero strobes. Without the macro → two strobes (8'hF0, then 8'h75).
- Stop after 5 data bits and idle for 25000 cycles → `frame_err` pulses once. A following 0x72 frame decodes correctly.
- Glitches shorter than 8 cycles on `ps2_clk` within a frame, and `iRST_n` pulsed low mid-frame → glitches ignored (0x74 decodes). After reset, all outputs = 0 and the next full 0x74 frame strobes.
